key_entry_display: RTL and testbench
====================================

Name: key_entry_display

Overview:
- Downstream consumer of the keypad scanner/debouncer.
- Turns the level-valid keycode stream into one accepted event per physical press, then edits a 6-digit entry buffer: digit/letter shift-in, backspace on `*` (code E), enter on `#` (code F).
- Drives the six seven-segment displays and presents a committed 24-bit entry value with a one-cycle strobe.

Parameters:
- RELEASE_CYCLES, 1024: consecutive cycles key_valid must stay low before a release is declared (re-arm).
- CNT_W, 11: width of the release counter; must satisfy 2**CNT_W > RELEASE_CYCLES.

Ports:
- clk, input, 1: system clock; all state updates on posedge.
- rst_n, input, 1: asynchronous, active-low reset.
- key_valid, input, 1: level, high while the scanner reports a debounced pressed key.
- key_code, input, 4: keycode; meaningful only while key_valid=1.
- entry_value, output, 24: last committed buffer; 6 nibbles, nibble 0 = last digit typed.
- entry_done, output, 1: one-cycle pulse when entry_value is updated.
- digit_count, output, 3: number of digits currently in the buffer (0..6).
- overflow, output, 1: sticky; set by a shift-in attempt while count=6; cleared by enter, backspace or reset.
- HEX0..HEX5, output, 7 each: active-low segments {g,f,e,d,c,b,a}; HEX0 = rightmost.

Behaviour:
- Reset values:
  - state = WAIT_REL, rel_cnt = 0.
  - buffer = 0, digit_count = 0, entry_value = 0.
  - entry_done = 0, overflow = 0.
  - HEX0..HEX5 = 7'h7F (blank).
- FSM states and transitions:
  - IDLE: if key_valid=1, capture key_code, perform the action, go to HELD.
  - HELD: stay while key_valid=1; key_code changes are ignored. If key_valid=0, set rel_cnt=1 and go to WAIT_REL.
  - WAIT_REL:
    - if key_valid=1: rel_cnt=0 and go to HELD, with no new action (bounce or glitch).
    - else: rel_cnt++; when rel_cnt reaches RELEASE_CYCLES-1, go to IDLE.
- Reset mid-press: the FSM starts in WAIT_REL, so a key held across reset is never accepted. It must be released for RELEASE_CYCLES cycles first.
- Actions: exactly one per accepted press, on the same edge that leaves IDLE.
  - Code 0–D, shift-in:
    - If count<6: buffer = {buffer[19:0], code}, count++.
    - Else: buffer unchanged, overflow=1.
  - Code E, backspace:
    - If count>0: buffer = {4'h0, buffer[23:4]}, count--.
    - Count=0: no change.
    - overflow=0 in both cases.
  - Code F, enter:
    - entry_value = buffer, entry_done=1 for exactly one cycle.
    - Then buffer=0, count=0, overflow=0.
    - Enter with count=0 still pulses and commits 0.
- Latency:
  - key_valid seen high at edge N (state IDLE) → buffer, count, entry_value and entry_done updated at edge N.
  - HEX outputs registered, updated at edge N+1.
- Display:
  - HEXi shows hex glyph of buffer[4i+3:4i] when i < count; otherwise 7'h7F (blank).
  - Count=0 → all blank.
  - Glyphs: standard 0–9, A, b, C, d; E and F never enter the buffer.
- Width rules:
  - count never exceeds 6 or underflows below 0.
  - rel_cnt saturates; it never wraps within one WAIT_REL stay.
- Simultaneous events: none possible, since there is a single input stream. Async rst_n overrides everything.

Decomposition:
- Package key_pkg:
  - state typedef {IDLE, HELD, WAIT_REL}.
  - constants KEY_BKSP=4'hE, KEY_ENTER=4'hF, MAX_DIGITS=6, SEG_BLANK=7'h7F.
- Sub-module hex7seg: combinational 4-bit → 7-segment active-low, instantiated six times. The output registers stay in the parent.

Test Plan:
- Reset with key_valid held high, then release < RELEASE_CYCLES and re-press → no accept. Release ≥ RELEASE_CYCLES then press code 5 → count=1, HEX0=7'h12, HEX1..HEX5 blank.
- Press 1,2,3 with a full release each; hold each 200 cycles → buffer=24'h000123, count=3. Holding never produces repeats.
- 7 presses of 1..7 → buffer=24'h123456, count=6, overflow=1. Then E → buffer=24'h012345, count=5, overflow=0.
- Bounce: key_valid drops for 10 cycles mid-hold, RELEASE_CYCLES=1024 → no second accept, state returns to HELD.
- Type A,B, then F → entry_value=24'h0000AB, entry_done high exactly 1 cycle, count=0, all HEX blank. F on empty → entry_done pulses, entry_value=0.
- rst_n asserted while in HELD with count=4 → immediate clear of all outputs to reset values, independent of clk.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and constants for the keypad entry/display block.
// Contents: entry FSM state type, special keycodes, buffer and display widths,
// and the blank seven-segment pattern.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

  localparam logic [3:0]  KEY_BKSP   = 4'hE;
  localparam logic [3:0]  KEY_ENTER  = 4'hF;
  localparam int unsigned MAX_DIGITS = 6;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BUF_W      = MAX_DIGITS * NIB_W;
  localparam int unsigned DCNT_W     = 3;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex-to-seven-segment decoder, active-low segments {g,f,e,d,c,b,a}.
// Ports: i_nib   - 4-bit value to show
//        o_seg_c - active-low segment pattern (combinational)
module hex7seg
  import key_pkg::*;
(
  input  logic [NIB_W-1:0] i_nib,
  output logic [SEG_W-1:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK;
    case (i_nib)
      4'h0: o_seg_c = 7'h40;
      4'h1: o_seg_c = 7'h79;
      4'h2: o_seg_c = 7'h24;
      4'h3: o_seg_c = 7'h30;
      4'h4: o_seg_c = 7'h19;
      4'h5: o_seg_c = 7'h12;
      4'h6: o_seg_c = 7'h02;
      4'h7: o_seg_c = 7'h78;
      4'h8: o_seg_c = 7'h00;
      4'h9: o_seg_c = 7'h10;
      4'hA: o_seg_c = 7'h08;
      4'hB: o_seg_c = 7'h03;
      4'hC: o_seg_c = 7'h46;
      4'hD: o_seg_c = 7'h21;
      4'hE: o_seg_c = 7'h06;
      4'hF: o_seg_c = 7'h0E;
      default: o_seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/key_entry_display.sv
// Keypad entry editor: one action per physical press, 6-digit shift buffer with
// backspace (E) and enter (F), committed value with strobe, six 7-seg displays.
// Ports: clk, rst_n        - clock, async active-low reset
//        key_valid         - level, debounced key pressed
//        key_code          - keycode, valid while key_valid=1
//        entry_value       - last committed buffer (nibble 0 = last typed)
//        entry_done        - one-cycle strobe when entry_value updates
//        digit_count       - digits in buffer (0..6)
//        overflow          - sticky shift-in-while-full flag
//        HEX0..HEX5        - active-low segments, HEX0 rightmost
module key_entry_display
  import key_pkg::*;
#(
  parameter int unsigned RELEASE_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic [BUF_W-1:0]  entry_value,
  output logic              entry_done,
  output logic [DCNT_W-1:0] digit_count,
  output logic              overflow,
  output logic [SEG_W-1:0]  HEX0,
  output logic [SEG_W-1:0]  HEX1,
  output logic [SEG_W-1:0]  HEX2,
  output logic [SEG_W-1:0]  HEX3,
  output logic [SEG_W-1:0]  HEX4,
  output logic [SEG_W-1:0]  HEX5
);

  localparam logic [CNT_W-1:0]  REL_LAST = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DIG_MAX  = DCNT_W'(MAX_DIGITS);

  state_e                             r_state, w_state_nxt;
  logic [CNT_W-1:0]                   r_rel_cnt, w_rel_nxt;
  logic [BUF_W-1:0]                   r_buf, w_buf_nxt;
  logic [DCNT_W-1:0]                  r_count, w_cnt_nxt;
  logic [BUF_W-1:0]                   r_entry, w_entry_nxt;
  logic                               r_done, w_done_nxt;
  logic                               r_ovf, w_ovf_nxt;
  logic [MAX_DIGITS-1:0][SEG_W-1:0]   r_hex;
  logic [MAX_DIGITS-1:0][SEG_W-1:0]   w_glyph;
  logic [MAX_DIGITS-1:0][SEG_W-1:0]   w_hex_nxt;

  // Press/release tracking and buffer edit; the action fires only on leaving IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_rel_nxt   = r_rel_cnt;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_count;
    w_entry_nxt = r_entry;
    w_done_nxt  = 1'b0;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      IDLE: begin
        if (key_valid) begin
          w_state_nxt = HELD;
          w_rel_nxt   = '0;
          if (key_code == KEY_ENTER) begin
            w_entry_nxt = r_buf;
            w_done_nxt  = 1'b1;
            w_buf_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
          end else if (key_code == KEY_BKSP) begin
            w_ovf_nxt = 1'b0;
            if (r_count != '0) begin
              w_buf_nxt = {NIB_W'(0), r_buf[BUF_W-1:NIB_W]};
              w_cnt_nxt = r_count - DCNT_W'(1);
            end
          end else if (r_count < DIG_MAX) begin
            w_buf_nxt = {r_buf[BUF_W-NIB_W-1:0], key_code};
            w_cnt_nxt = r_count + DCNT_W'(1);
          end else begin
            w_ovf_nxt = 1'b1;
          end
        end
      end
      HELD: begin
        if (!key_valid) begin
          w_state_nxt = WAIT_REL;
          w_rel_nxt   = CNT_W'(1);
        end
      end
      WAIT_REL: begin
        // A short high blip is bounce: back to HELD without a new action.
        if (key_valid) begin
          w_state_nxt = HELD;
          w_rel_nxt   = '0;
        end else if (r_rel_cnt >= REL_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_rel_nxt = r_rel_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = WAIT_REL;
    endcase
  end

  // Display glyphs follow the current buffer, blank above the digit count.
  for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_dig
    hex7seg u_seg (
      .i_nib   (r_buf[NIB_W*gi +: NIB_W]),
      .o_seg_c (w_glyph[gi])
    );
    assign w_hex_nxt[gi] = (r_count > DCNT_W'(gi)) ? w_glyph[gi] : SEG_BLANK;
  end

  // State and output registers; reset starts in WAIT_REL so a held key is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= WAIT_REL;
      r_rel_cnt <= '0;
      r_buf     <= '0;
      r_count   <= '0;
      r_entry   <= '0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_hex     <= {MAX_DIGITS{SEG_BLANK}};
    end else begin
      r_state   <= w_state_nxt;
      r_rel_cnt <= w_rel_nxt;
      r_buf     <= w_buf_nxt;
      r_count   <= w_cnt_nxt;
      r_entry   <= w_entry_nxt;
      r_done    <= w_done_nxt;
      r_ovf     <= w_ovf_nxt;
      r_hex     <= w_hex_nxt;
    end
  end

  assign entry_value = r_entry;
  assign entry_done  = r_done;
  assign digit_count = r_count;
  assign overflow    = r_ovf;
  assign HEX0        = r_hex[0];
  assign HEX1        = r_hex[1];
  assign HEX2        = r_hex[2];
  assign HEX3        = r_hex[3];
  assign HEX4        = r_hex[4];
  assign HEX5        = r_hex[5];

endmodule

// File: tb/tb_key_entry_display.sv
// Self-checking bench for key_entry_display against a press-level reference model.
module tb_key_entry_display;

  localparam int unsigned RC        = 1024;
  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code  = 4'h0;
  logic [23:0] entry_value;
  logic        entry_done;
  logic [2:0]  digit_count;
  logic        overflow;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [41:0] hex_all;
  logic [70:0] dut_vec;

  int checks   = 0;
  int failures = 0;

  // Reference model: a press is accepted when key_valid is high after at
  // least RC consecutive low cycles (counted from reset or the last high).
  int unsigned m_low_run;
  int unsigned m_digits[$];   // typing order, last element = most recent
  logic [23:0] m_entry;
  logic        m_done;
  logic        m_ovf;
  logic [41:0] m_hex;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  assign dut_vec = {entry_value, entry_done, digit_count, overflow, hex_all};

  key_entry_display #(.RELEASE_CYCLES(RC), .CNT_W(11)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .entry_value (entry_value),
    .entry_done  (entry_done),
    .digit_count (digit_count),
    .overflow    (overflow),
    .HEX0        (HEX0),
    .HEX1        (HEX1),
    .HEX2        (HEX2),
    .HEX3        (HEX3),
    .HEX4        (HEX4),
    .HEX5        (HEX5)
  );

  function automatic logic [23:0] m_buf();
    int unsigned v = 0;
    int n = m_digits.size();
    for (int k = 0; k < n; k++) v += m_digits[k] << (4 * (n - 1 - k));
    return 24'(v);
  endfunction

  function automatic logic [41:0] m_disp();
    logic [41:0] v = ALL_BLANK;
    logic [23:0] b = m_buf();
    int n = m_digits.size();
    for (int i = 0; i < n; i++) v[7*i +: 7] = glyph_tab[b[4*i +: 4]];
    return v;
  endfunction

  function automatic logic [70:0] m_vec();
    return {m_entry, m_done, 3'(m_digits.size()), m_ovf, m_hex};
  endfunction

  task automatic model_accept(input logic [3:0] code);
    if (code == 4'hF) begin
      m_entry = m_buf();
      m_done  = 1'b1;
      m_digits.delete();
      m_ovf   = 1'b0;
    end else if (code == 4'hE) begin
      m_ovf = 1'b0;
      if (m_digits.size() > 0) void'(m_digits.pop_back());
    end else if (m_digits.size() < 6) begin
      m_digits.push_back(32'(code));
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  // Drive one cycle of input and advance the model across that clock edge.
  task automatic step(input logic kv, input logic [3:0] code);
    key_valid = kv;
    key_code  = code;
    m_hex  = m_disp();
    m_done = 1'b0;
    if (kv && m_low_run >= RC) model_accept(code);
    if (kv) m_low_run = 0;
    else if (m_low_run < RC) m_low_run++;
    @(posedge clk);
    #1;
  endtask

  task automatic hold_key(input logic [3:0] code, input int n);
    step(1'b1, code);
    for (int c = 1; c < n; c++) step(1'b1, 4'($urandom_range(0, 15)));
  endtask

  task automatic idle_low(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 4'($urandom_range(0, 15)));
  endtask

  task automatic assert_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_digits.delete();
    m_low_run = 0;
    m_entry   = '0;
    m_done    = 1'b0;
    m_ovf     = 1'b0;
    m_hex     = ALL_BLANK;
  endtask

  task automatic release_reset();
    #1 rst_n = 1'b1;
  endtask

  task automatic fresh_start();
    assert_reset();
    release_reset();
    idle_low(RC);
  endtask

  task automatic test_reset();
    key_valid = 1'b1;
    key_code  = 4'h5;
    assert_reset();
    #1;
    checks++;
    if (dut_vec !== 71'(ALL_BLANK)) begin
      failures++;
      $display("FAIL reset_values: got %h want %h", dut_vec, 71'(ALL_BLANK));
    end
    release_reset();
    hold_key(4'h5, 50);
    checks++;
    if (digit_count !== 3'd0) begin
      failures++;
      $display("FAIL held_across_reset: count got %0d want 0", digit_count);
    end
    idle_low(RC - 1);
    hold_key(4'h5, 20);
    checks++;
    if (dut_vec !== m_vec()) begin
      failures++;
      $display("FAIL short_release: got %h want %h", dut_vec, m_vec());
    end
    idle_low(RC);
    hold_key(4'h5, 20);
    checks++;
    if (digit_count !== 3'd1) begin
      failures++;
      $display("FAIL full_release_accept: count got %0d want 1", digit_count);
    end
    checks++;
    if (hex_all !== {{5{7'h7F}}, 7'h12}) begin
      failures++;
      $display("FAIL hex_after_5: got %h want %h", hex_all, {{5{7'h7F}}, 7'h12});
    end
  endtask

  task automatic test_shift_in();
    fresh_start();
    for (int d = 1; d <= 3; d++) begin
      hold_key(4'(d), 200);
      checks++;
      if (digit_count !== 3'(d)) begin
        failures++;
        $display("FAIL shift_count_%0d: got %0d want %0d", d, digit_count, d);
      end
      idle_low(RC + $urandom_range(0, 5));
    end
    checks++;
    if (hex_all !== {{3{7'h7F}}, 7'h79, 7'h24, 7'h30}) begin
      failures++;
      $display("FAIL hex_123: got %h want %h", hex_all, {{3{7'h7F}}, 7'h79, 7'h24, 7'h30});
    end
    checks++;
    if (dut_vec !== m_vec()) begin
      failures++;
      $display("FAIL shift_model: got %h want %h", dut_vec, m_vec());
    end
  endtask

  task automatic test_overflow_backspace();
    fresh_start();
    for (int d = 1; d <= 7; d++) begin
      hold_key(4'(d), $urandom_range(1, 30));
      idle_low(RC);
    end
    checks++;
    if ({digit_count, overflow} !== {3'd6, 1'b1}) begin
      failures++;
      $display("FAIL overflow_full: got cnt=%0d ovf=%b want cnt=6 ovf=1", digit_count, overflow);
    end
    checks++;
    if (hex_all !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}) begin
      failures++;
      $display("FAIL hex_123456: got %h want %h", hex_all, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
    end
    hold_key(4'hE, 10);
    checks++;
    if ({digit_count, overflow} !== {3'd5, 1'b0}) begin
      failures++;
      $display("FAIL bksp_after_ovf: got cnt=%0d ovf=%b want cnt=5 ovf=0", digit_count, overflow);
    end
    checks++;
    if (dut_vec !== m_vec()) begin
      failures++;
      $display("FAIL bksp_model: got %h want %h", dut_vec, m_vec());
    end
    for (int b = 0; b < 6; b++) begin
      idle_low(RC);
      hold_key(4'hE, 5);
    end
    checks++;
    if ({digit_count, hex_all} !== {3'd0, ALL_BLANK}) begin
      failures++;
      $display("FAIL bksp_empty: got cnt=%0d hex=%h want cnt=0 blank", digit_count, hex_all);
    end
  endtask

  task automatic test_bounce();
    fresh_start();
    hold_key(4'h7, 50);
    idle_low(10);
    hold_key(4'h7, 50);
    idle_low(RC - 1);
    hold_key(4'h8, 30);
    checks++;
    if (digit_count !== 3'd1) begin
      failures++;
      $display("FAIL bounce_no_repeat: count got %0d want 1", digit_count);
    end
    idle_low(RC);
    hold_key(4'h8, 30);
    checks++;
    if (dut_vec !== m_vec()) begin
      failures++;
      $display("FAIL after_bounce_press: got %h want %h", dut_vec, m_vec());
    end
  endtask

  task automatic test_enter();
    int dut_pulses;
    fresh_start();
    hold_key(4'hA, 20);
    idle_low(RC);
    hold_key(4'hB, 20);
    idle_low(RC);
    for (int pass = 0; pass < 2; pass++) begin
      dut_pulses = 0;
      for (int c = 0; c < 8; c++) begin
        step(1'b1, (c == 0) ? 4'hF : 4'($urandom_range(0, 15)));
        if (entry_done === 1'b1) dut_pulses++;
        checks++;
        if (entry_done !== m_done) begin
          failures++;
          $display("FAIL enter_strobe_cycle%0d: got %b want %b", c, entry_done, m_done);
        end
      end
      checks++;
      if (dut_pulses != 1) begin
        failures++;
        $display("FAIL enter_pulse_count: got %0d want 1", dut_pulses);
      end
      checks++;
      if (entry_value !== ((pass == 0) ? 24'h0000AB : 24'h000000)) begin
        failures++;
        $display("FAIL enter_value_pass%0d: got %h want %h", pass, entry_value,
                 (pass == 0) ? 24'h0000AB : 24'h000000);
      end
      checks++;
      if ({digit_count, overflow, hex_all} !== {3'd0, 1'b0, ALL_BLANK}) begin
        failures++;
        $display("FAIL enter_clears: got cnt=%0d ovf=%b hex=%h", digit_count, overflow, hex_all);
      end
      idle_low(RC);
    end
  endtask

  task automatic test_random();
    logic kv;
    for (int p = 0; p < 14; p++) begin
      int rel = RC - 2 + $urandom_range(0, 4);
      int hold = $urandom_range(1, 20);
      for (int c = 0; c < hold + rel; c++) begin
        kv = (c < hold) || ($urandom_range(0, 199) == 0);
        step(kv, 4'($urandom_range(0, 15)));
        checks++;
        if (dut_vec !== m_vec()) begin
          failures++;
          $display("FAIL random_p%0d_c%0d: got %h want %h", p, c, dut_vec, m_vec());
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    fresh_start();
    for (int d = 0; d < 3; d++) begin
      hold_key(4'($urandom_range(0, 13)), 10);
      idle_low(RC);
    end
    hold_key(4'hC, 30);
    checks++;
    if (digit_count !== 3'd4) begin
      failures++;
      $display("FAIL pre_reset_count: got %0d want 4", digit_count);
    end
    assert_reset();
    #1;
    checks++;
    if (dut_vec !== 71'(ALL_BLANK)) begin
      failures++;
      $display("FAIL async_reset_clear: got %h want %h", dut_vec, 71'(ALL_BLANK));
    end
    release_reset();
    hold_key(4'hC, 40);
    checks++;
    if (dut_vec !== m_vec()) begin
      failures++;
      $display("FAIL held_after_reset: got %h want %h", dut_vec, m_vec());
    end
  endtask

  initial begin
    test_reset();
    test_shift_in();
    test_overflow_backspace();
    test_bounce();
    test_enter();
    test_random();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
